// File: rtl/stack_ctrl_if.sv
// Command/response bundle between the stack-machine core and the stack controller.
interface stack_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              err;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, resp_valid, resp_data,
    input  err, count, full, empty
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, resp_valid, resp_data,
    output err, count, full, empty
  );
endinterface

// File: rtl/stack_ctrl.sv
// LIFO operand-stack controller sequencing a 16x8 register file.
// PUSH/POP/DUP are single-cycle; SWAP runs through a small FSM.
module stack_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  stack_ctrl_if.slave       bus,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_we
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SWAP_B, SWAP_W} state_t;

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] tmp_a;
  logic [DATA_W-1:0] tmp_b;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              err;

  logic            full, empty, accept;
  logic            is_push, is_pop, is_dup, is_swap;
  logic            push_ok, pop_ok, dup_ok, swap_ok, reject;
  logic [ADDR_W:0] cnt_m1, cnt_m2, cnt_p1;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign cnt_m1 = count - ONE;
  assign cnt_m2 = count - TWO;
  assign cnt_p1 = count + ONE;

  assign accept  = bus.cmd_valid && (state == IDLE);
  assign is_push = accept && (bus.cmd_op == 3'd1);
  assign is_pop  = accept && (bus.cmd_op == 3'd2);
  assign is_dup  = accept && (bus.cmd_op == 3'd3);
  assign is_swap = accept && (bus.cmd_op == 3'd4);

  assign push_ok = is_push && !full;
  assign pop_ok  = is_pop && !empty;
  assign dup_ok  = is_dup && !empty && !full;
  assign swap_ok = is_swap && (count >= TWO);
  assign reject  = (is_push && full) || (is_pop && empty) ||
                   (is_dup && (empty || full)) ||
                   (is_swap && (count < TWO));

  always_comb begin
    rf_read_addr = '0;
    if (state == SWAP_B)
      rf_read_addr = cnt_m2[ADDR_W-1:0];
    else if (!empty)
      rf_read_addr = cnt_m1[ADDR_W-1:0];
  end

  // Write port is gated by rst so an aborted SWAP never lands.
  always_comb begin
    rf_we         = 1'b0;
    rf_write_addr = '0;
    rf_data_in    = '0;
    if (!rst) begin
      unique case (1'b1)
        state == SWAP_B: begin
          rf_we         = 1'b1;
          rf_write_addr = cnt_m2[ADDR_W-1:0];
          rf_data_in    = tmp_a;
        end
        state == SWAP_W: begin
          rf_we         = 1'b1;
          rf_write_addr = cnt_m1[ADDR_W-1:0];
          rf_data_in    = tmp_b;
        end
        push_ok: begin
          rf_we         = 1'b1;
          rf_write_addr = count[ADDR_W-1:0];
          rf_data_in    = bus.cmd_data;
        end
        dup_ok: begin
          rf_we         = 1'b1;
          rf_write_addr = count[ADDR_W-1:0];
          rf_data_in    = rf_data_out;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      tmp_a      <= '0;
      tmp_b      <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      err        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (push_ok || dup_ok)
            count <= cnt_p1;
          if (pop_ok) begin
            count      <= cnt_m1;
            resp_data  <= rf_data_out;
            resp_valid <= 1'b1;
          end
          if (swap_ok) begin
            tmp_a <= rf_data_out;
            state <= SWAP_B;
          end
          if (reject)
            err <= 1'b1;
        end
        SWAP_B: begin
          tmp_b <= rf_data_out;
          state <= SWAP_W;
        end
        SWAP_W:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.err        = err;
  assign bus.count      = count;
  assign bus.full       = full;
  assign bus.empty      = empty;
endmodule
